// File: rtl/lcdi_line_feeder_pkg.sv
// rtl/lcdi_line_feeder_pkg.sv - pixel width, bank count and FSM encoding shared by the LCDI line feeder
package lcdi_line_feeder_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int NUM_BANKS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/lcdi_line_bank.sv
// rtl/lcdi_line_bank.sv - one source line of pixel storage: single write port, registered read port
module lcdi_line_bank #(
   parameter int DEPTH = 960,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lcdi_line_feeder.sv
// rtl/lcdi_line_feeder.sv - four-bank line buffer presenting a 3-row window; LCDI_FEEDER_MIRROR_EN selects mirror edges
module lcdi_line_feeder
   import lcdi_line_feeder_pkg::*;
#(
   parameter int IMG_W     = 960,
   parameter int IMG_H     = 540,
   parameter int COL_STEPS = 963
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] pix_in,
   input  logic                  pix_in_valid,
   input  logic                  pix_in_sof,
   output logic                  pix_in_ready,
   output logic [DATA_WIDTH-1:0] data0_out,
   output logic [DATA_WIDTH-1:0] data1_out,
   output logic [DATA_WIDTH-1:0] data2_out,
   output logic                  frame_start,
   input  logic                  data_in_valid,
   output logic                  sof_err
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H + 1);
   localparam int CW = $clog2(COL_STEPS);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_END  = YW'(IMG_H);
   localparam logic [CW-1:0] C_LAST = CW'(COL_STEPS - 1);

   feeder_state_t         state_q, state_d;
   logic [XW-1:0]         fill_col_q;
   logic [YW-1:0]         fill_line_q;
   logic [YW-1:0]         row_q;
   logic [CW-1:0]         col_q;
   logic                  frame_start_q, sof_err_q, out_vld_q;
   logic [1:0]            sel_q [3];
   logic [1:0]            sel_d [3];
   logic [XW-1:0]         raddr, waddr;
   logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];
   logic                  fill_open, accept, sof_acc, pix_acc, row_ok, adv, line_last, col_last;

   // Out-of-frame row numbers fold back onto a stored line before picking its bank.
   function automatic logic [1:0] bank_of(input int line);
      int l;
      l = line;
`ifdef LCDI_FEEDER_MIRROR_EN
      if (l < 0) l = 1;
      else if (l > IMG_H - 1) l = IMG_H - 2;
`else
      if (l < 0) l = 0;
      else if (l > IMG_H - 1) l = IMG_H - 1;
`endif
      return l[1:0];
   endfunction

   always_comb begin
      int ctr, cc;
      ctr = (int'(row_q) > IMG_H - 1) ? IMG_H - 1 : int'(row_q);
      cc  = int'(col_q) - 3;
      if (cc < 0) cc = 0;
      else if (cc > IMG_W - 1) cc = IMG_W - 1;
      raddr    = XW'(cc);
      sel_d[0] = bank_of(ctr - 1);
      sel_d[1] = bank_of(ctr);
      sel_d[2] = bank_of(ctr + 1);
   end

   // A new line may only overwrite the bank of a line the window no longer needs.
   always_comb begin
      fill_open = 1'b0;
      case (state_q)
         ST_IDLE, ST_PRIME: fill_open = 1'b1;
         ST_RUN:  fill_open = (fill_line_q != Y_END) && (int'(fill_line_q) <= int'(row_q) + 2);
         default: fill_open = 1'b0;
      endcase
   end

   assign pix_in_ready = rst_n & fill_open;
   assign accept       = pix_in_valid & pix_in_ready;
   assign sof_acc      = accept & pix_in_sof;
   assign pix_acc      = accept & ~pix_in_sof & (state_q != ST_IDLE);
   assign line_last    = (fill_col_q == X_LAST);
   assign col_last     = (col_q == C_LAST);
   assign row_ok       = int'(fill_line_q) >= ((int'(row_q) + 2 > IMG_H) ? IMG_H : int'(row_q) + 2);
   assign adv          = data_in_valid & row_ok & ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign waddr        = sof_acc ? '0 : fill_col_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PRIME: if (pix_acc && line_last && fill_line_q == YW'(1)) state_d = ST_RUN;
         ST_RUN:   if (fill_line_q == Y_END) state_d = ST_DRAIN;
         ST_DRAIN: if (adv && col_last && row_q == Y_END) state_d = ST_IDLE;
         default:  state_d = state_q;
      endcase
      if (sof_acc) state_d = ST_PRIME;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         fill_col_q    <= '0;
         fill_line_q   <= '0;
         row_q         <= '0;
         col_q         <= '0;
         frame_start_q <= 1'b0;
         sof_err_q     <= 1'b0;
         out_vld_q     <= 1'b0;
         for (int i = 0; i < 3; i++) sel_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         frame_start_q <= (state_q == ST_PRIME) && pix_acc && line_last && (fill_line_q == YW'(1));
         if (sof_acc && state_q != ST_IDLE) sof_err_q <= 1'b1;
         if (sof_acc) begin
            fill_line_q <= '0;
            fill_col_q  <= XW'(1);
         end else if (pix_acc) begin
            if (line_last) begin
               fill_col_q  <= '0;
               fill_line_q <= fill_line_q + 1'b1;
            end else begin
               fill_col_q <= fill_col_q + 1'b1;
            end
         end
         if (sof_acc) begin
            row_q <= '0;
            col_q <= '0;
         end else if (adv) begin
            if (col_last) begin
               col_q <= '0;
               row_q <= (row_q == Y_END) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         if (adv) begin
            out_vld_q <= 1'b1;
            for (int i = 0; i < 3; i++) sel_q[i] <= sel_d[i];
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic we;
      assign we = (sof_acc && b == 0) || (pix_acc && fill_line_q[1:0] == 2'(b));
      lcdi_line_bank #(.DEPTH(IMG_W), .DW(DATA_WIDTH)) u_bank (
         .clk   (clk),
         .we    (we),
         .waddr (waddr),
         .wdata (pix_in),
         .re    (adv),
         .raddr (raddr),
         .rdata (bank_rd[b])
      );
   end

   assign data0_out   = out_vld_q ? bank_rd[sel_q[0]] : '0;
   assign data1_out   = out_vld_q ? bank_rd[sel_q[1]] : '0;
   assign data2_out   = out_vld_q ? bank_rd[sel_q[2]] : '0;
   assign frame_start = frame_start_q;
   assign sof_err     = sof_err_q;

endmodule
